// File: rtl/pipe_stage_buffer.sv
// Two-entry pipeline stage buffer (main + skid) with halt, flush, bubble
// insertion on empty output, and a saturating stall counter.
module pipe_stage_buffer #(
  parameter int                DATA_W     = 16,
  parameter int                NUM_FIELDS = 6,
  parameter int                NOP_FIELD  = 5,
  parameter logic [DATA_W-1:0] NOP_INST   = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [15:0]                  stall_cnt
);

  localparam int TOTAL_W = NUM_FIELDS * DATA_W;

  logic               r_mainValid;
  logic [TOTAL_W-1:0] r_mainData;
  logic               r_skidValid;
  logic [TOTAL_W-1:0] r_skidData;
  logic [15:0]        r_stallCnt;

  logic               w_accept;
  logic               w_pop;
  logic               w_stall;
  logic [TOTAL_W-1:0] w_bubble;

  always_comb begin
    w_bubble = '0;
    w_bubble[NOP_FIELD*DATA_W +: DATA_W] = NOP_INST;
  end

  assign in_ready  = !halt && !flush && !r_skidValid;
  assign out_valid = r_mainValid && !halt;
  assign out_data  = r_mainValid ? r_mainData : w_bubble;
  assign occupancy = {1'b0, r_mainValid} + {1'b0, r_skidValid};
  assign stall_cnt = r_stallCnt;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_stall  = (halt && r_mainValid) || (out_valid && !out_ready);

  // The skid entry only ever fills while main is occupied, so a pop always
  // promotes skid first; a new beat can only land in main when skid is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mainValid <= 1'b0;
      r_mainData  <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (!halt) begin
      if (w_pop) begin
        if (r_skidValid) begin
          r_mainData  <= r_skidData;
          r_skidValid <= 1'b0;
        end else if (w_accept) begin
          r_mainData <= in_data;
        end else begin
          r_mainValid <= 1'b0;
        end
      end else if (w_accept) begin
        if (r_mainValid) begin
          r_skidData  <= in_data;
          r_skidValid <= 1'b1;
        end else begin
          r_mainData  <= in_data;
          r_mainValid <= 1'b1;
        end
      end
    end
  end

  // Counter deliberately survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer with hand-computed
// expected values for delivery order, halt, flush, reset and saturation.
module tb_pipe_stage_buffer;

  localparam int DW = 16;
  localparam int NF = 6;
  localparam int TW = DW * NF;

  logic          clk;
  logic          rst;
  logic          halt;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  int nChecks;
  int nErrors;

  pipe_stage_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TW-1:0] rep(input logic [DW-1:0] f);
    return {NF{f}};
  endfunction

  task automatic checkOutput(input string tag, input logic [TW-1:0] observed,
                             input logic [TW-1:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] f, input logic ordy);
    in_valid  = v;
    in_data   = rep(f);
    out_ready = ordy;
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    nChecks  = 0;
    nErrors  = 0;
    rst      = 1'b0;
    halt     = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("rst_occ",    TW'(occupancy), TW'(0));
    checkOutput("rst_ovalid", TW'(out_valid), TW'(0));
    checkOutput("rst_odata",  out_data, '0);
    checkOutput("rst_stall",  TW'(stall_cnt), TW'(0));
    rst = 1'b1;
    #1;
    checkOutput("rst_iready", TW'(in_ready), TW'(1));

    // single beat
    tick();
    applyStimulus(1'b1, 16'hAAAA, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("single_data",   out_data, rep(16'hAAAA));
    checkOutput("single_ovalid", TW'(out_valid), TW'(1));
    checkOutput("single_occ",    TW'(occupancy), TW'(1));
    tick();
    checkOutput("single_drain",  TW'(occupancy), TW'(0));

    // skid fill and ordered drain
    applyStimulus(1'b1, 16'h1111, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h2222, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("skid_occ",    TW'(occupancy), TW'(2));
    checkOutput("skid_iready", TW'(in_ready), TW'(0));
    checkOutput("skid_head",   out_data, rep(16'h1111));
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("skid_pop1_valid", TW'(out_valid), TW'(1));
    tick();
    checkOutput("skid_pop2_data", out_data, rep(16'h2222));
    checkOutput("skid_pop2_occ",  TW'(occupancy), TW'(1));
    checkOutput("skid_iready_back", TW'(in_ready), TW'(1));
    tick();
    checkOutput("skid_empty", TW'(occupancy), TW'(0));
    checkOutput("skid_stall", TW'(stall_cnt), TW'(1));

    // halt, starting from a clean counter
    pulseReset();
    applyStimulus(1'b1, 16'hCCCC, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    halt = 1'b1;
    #1;
    checkOutput("halt_ovalid", TW'(out_valid), TW'(0));
    checkOutput("halt_iready", TW'(in_ready), TW'(0));
    repeat (3) tick();
    checkOutput("halt_data",  out_data, rep(16'hCCCC));
    checkOutput("halt_occ",   TW'(occupancy), TW'(1));
    checkOutput("halt_stall", TW'(stall_cnt), TW'(3));
    halt = 1'b0;
    #1;
    checkOutput("halt_rel_valid", TW'(out_valid), TW'(1));
    checkOutput("halt_rel_data",  out_data, rep(16'hCCCC));
    tick();
    checkOutput("halt_once_occ",   TW'(occupancy), TW'(0));
    checkOutput("halt_once_valid", TW'(out_valid), TW'(0));

    // flush with a beat offered in the same cycle
    applyStimulus(1'b1, 16'h3333, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h4444, 1'b0);
    tick();
    checkOutput("flush_pre_occ", TW'(occupancy), TW'(2));
    applyStimulus(1'b1, 16'h5555, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush_iready", TW'(in_ready), TW'(0));
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("flush_occ",    TW'(occupancy), TW'(0));
    checkOutput("flush_ovalid", TW'(out_valid), TW'(0));
    checkOutput("flush_bubble", out_data, '0);
    repeat (3) tick();
    checkOutput("flush_no5555", TW'(out_valid), TW'(0));
    checkOutput("flush_keeps_stall", TW'(stall_cnt), TW'(5));

    // asynchronous reset between edges while full
    applyStimulus(1'b1, 16'h6666, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h7777, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("arst_pre_occ", TW'(occupancy), TW'(2));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_occ",    TW'(occupancy), TW'(0));
    checkOutput("arst_ovalid", TW'(out_valid), TW'(0));
    checkOutput("arst_data",   out_data, '0);
    checkOutput("arst_stall",  TW'(stall_cnt), TW'(0));
    checkOutput("arst_iready", TW'(in_ready), TW'(1));
    rst = 1'b1;
    applyStimulus(1'b1, 16'h8888, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("arst_first_data", out_data, rep(16'h8888));
    checkOutput("arst_first_occ",  TW'(occupancy), TW'(1));
    tick();
    checkOutput("arst_first_done", TW'(occupancy), TW'(0));

    // stall counter saturation
    pulseReset();
    applyStimulus(1'b1, 16'h9999, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat_value", TW'(stall_cnt), TW'(16'hFFFF));
    repeat (3) tick();
    checkOutput("sat_hold",  TW'(stall_cnt), TW'(16'hFFFF));
    checkOutput("sat_data",  out_data, rep(16'h9999));
    checkOutput("sat_valid", TW'(out_valid), TW'(1));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, width of one field in bits.
REQ-002 The block SHALL have parameter NUM_FIELDS, default 6, number of fields per beat (control, ALU, sign-ext, instruction, etc.).
REQ-003 The block SHALL have parameter NOP_FIELD, default 5, index of the field that carries the instruction.
REQ-004 The block SHALL have parameter NOP_INST, default 16'h0000, instruction value used when inserting a bubble.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port halt, input, 1 bit: freezes the stage.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronously discards all held beats.
REQ-009 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-010 The block SHALL have port in_ready, output, 1 bit: stage can accept a beat.
REQ-011 The block SHALL have port in_data, input, NUM_FIELDS*DATA_W bits: packed fields, field 0 in the LSBs.
REQ-012 The block SHALL have port out_valid, output, 1 bit: beat presented downstream.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream takes the beat.
REQ-014 The block SHALL have port out_data, output, NUM_FIELDS*DATA_W bits, with the same packing as in_data.
REQ-015 The block SHALL have port occupancy, output, 2 bits: beats held, range 0..2.
REQ-016 The block SHALL have port stall_cnt, output, 16 bits: count of stalled cycles.

Function
REQ-017 Storage SHALL be two entries: main, which drives out_data, and skid; delivery order SHALL be FIFO with no loss or duplication.
REQ-018 in_ready SHALL equal (!halt && !flush && skid empty), combinationally.
REQ-019 Accept SHALL occur when (in_valid && in_ready); pop SHALL occur when (out_valid && out_ready).
REQ-020 out_valid SHALL equal (main valid && !halt); out_data SHALL show main contents whenever main is valid, including during halt.
REQ-021 When main is invalid, out_data SHALL show the bubble value: field NOP_FIELD = NOP_INST, all other fields 0.
REQ-022 Latency SHALL be one cycle: a beat accepted into an empty stage appears on out_data with out_valid=1 on the next cycle.
REQ-023 Occupancy 1, accept without pop: the beat SHALL go to skid, occupancy becomes 2, and in_ready drops next cycle.
REQ-024 Occupancy 1, accept with pop in the same cycle: the new beat SHALL load main and occupancy stays 1.
REQ-025 Occupancy 2, pop: skid SHALL move to main, occupancy becomes 1, and in_ready rises next cycle if halt=0.
REQ-026 halt=1: no accept and no pop SHALL occur, and all registers SHALL hold; out_ready is ignored.
REQ-027 flush=1: next cycle occupancy SHALL be 0, out_valid 0, out_data the bubble value, and any beat offered that cycle SHALL be dropped.
REQ-028 flush SHALL take priority over halt, accept and pop.
REQ-029 stall_cnt SHALL increment each cycle in which (halt && main valid) or (out_valid && !out_ready).
REQ-030 stall_cnt SHALL saturate at 16'hFFFF and SHALL NOT be cleared by flush.

Reset
REQ-031 rst=0 SHALL immediately force occupancy=0, out_valid=0, out_data=bubble value, stall_cnt=0, and both entries invalid.
REQ-032 in_ready SHALL be 1 after reset whenever halt=0 and flush=0.
REQ-033 Reset asserted mid-transfer SHALL discard all held beats; the first beat after release SHALL behave as accepted into an empty stage.

Verification
REQ-034 The bench SHALL check single beat: in_data all fields 16'hAAAA, in_valid=1, out_ready=1 -> next cycle out_data all 16'hAAAA, out_valid=1, occupancy=1.
REQ-035 The bench SHALL check skid fill: beats 16'h1111 then 16'h2222 with out_ready=0 -> occupancy=2, in_ready=0; then out_ready=1 -> 1111 delivered, then 2222, in order.
REQ-036 The bench SHALL check halt: occupancy 1 holding 16'hCCCC, halt=1 for 3 cycles with out_ready=1 -> out_valid=0, data held at CCCC, in_ready=0, stall_cnt=3; release -> CCCC delivered once.
REQ-037 The bench SHALL check flush: occupancy 2, with flush=1 and in_valid=1 (16'h5555) in the same cycle -> next cycle occupancy=0, out_data field 5=16'h0000, others 0, 5555 never delivered.
REQ-038 The bench SHALL check saturation: out_valid=1 with out_ready=0 for 65540 cycles -> stall_cnt=16'hFFFF and stays there.
REQ-039 The bench SHALL check async reset: rst driven low between clock edges with occupancy 2 -> outputs at reset values before the next edge.
